// File: rtl/i2c_cfg_sequencer.sv
// i2c_cfg_sequencer: walks a ROM table of 32-bit config words into the I2C configure block.
// Defining I2C_SEQ_DELAY_CMD_EN turns 8'hFE words into millisecond delay commands.
module i2c_cfg_sequencer #(
  parameter int unsigned TBL_AW       = 8,
  parameter int unsigned GAP_CYCLES   = 24000,
  parameter int unsigned ACK_TIMEOUT  = 240000,
  parameter int unsigned DONE_TIMEOUT = 2400000,
  parameter logic [31:0] END_WORD     = 32'hFFFF_FFFF
) (
  input  logic              clk_24m,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [TBL_AW-1:0] cur_index,
  output logic [TBL_AW-1:0] tbl_addr,
  input  logic [31:0]       tbl_data,
  output logic              configure_en,
  output logic [31:0]       configure_data,
  input  logic              configure_rdy
);
  localparam int unsigned MAX_AG = ACK_TIMEOUT > GAP_CYCLES ? ACK_TIMEOUT : GAP_CYCLES;
  localparam int unsigned MAXP = DONE_TIMEOUT > MAX_AG ? DONE_TIMEOUT : MAX_AG;
  localparam int CW = $clog2(MAXP + 1);
  typedef enum logic [3:0] {IDLE, FETCH, CHECK, ISSUE, WAIT_DONE, GAP, DELAY, DONE, ERR} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [TBL_AW-1:0] index;
  logic rdy_m, rdy_s, gap_end, last;
`ifdef I2C_SEQ_DELAY_CMD_EN
  logic [15:0] ms;
`endif
  assign gap_end = cnt >= CW'(GAP_CYCLES - 1);
  assign last = index == {TBL_AW{1'b1}};
  assign tbl_addr = index;
  assign cur_index = index;
  assign configure_en = state == ISSUE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = start ? FETCH : IDLE;
      FETCH:     state_n = cnt != '0 ? CHECK : FETCH;
`ifdef I2C_SEQ_DELAY_CMD_EN
      CHECK:     state_n = configure_data == END_WORD ? DONE :
                           configure_data[31:24] == 8'hFE ? DELAY : rdy_s ? ISSUE : CHECK;
      DELAY:     state_n = ms >= configure_data[15:0] ? GAP : DELAY;
`else
      CHECK:     state_n = configure_data == END_WORD ? DONE : rdy_s ? ISSUE : CHECK;
`endif
      ISSUE:     state_n = !rdy_s ? WAIT_DONE : cnt >= CW'(ACK_TIMEOUT) ? ERR : ISSUE;
      WAIT_DONE: state_n = rdy_s ? GAP : cnt >= CW'(DONE_TIMEOUT) ? ERR : WAIT_DONE;
      GAP:       state_n = !gap_end ? GAP : last ? DONE : FETCH;
      DONE:      state_n = IDLE;
      ERR:       state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_24m) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      index <= '0;
      configure_data <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
      rdy_m <= 1'b0;
      rdy_s <= 1'b0;
`ifdef I2C_SEQ_DELAY_CMD_EN
      ms <= '0;
`endif
    end else begin
      rdy_m <= configure_rdy;
      rdy_s <= rdy_m;
      state <= state_n;
      cnt <= (state_n != state || state == IDLE || state == CHECK) ? '0 : cnt + CW'(1);
`ifdef I2C_SEQ_DELAY_CMD_EN
      ms <= state != DELAY ? '0 : ms + 16'(gap_end);
      if (state == DELAY && gap_end) cnt <= '0;
`endif
      if (state == IDLE && start) begin
        busy <= 1'b1;
        done <= 1'b0;
        error <= 1'b0;
        index <= '0;
      end
      if (state == FETCH && cnt != '0) configure_data <= tbl_data;
      if (state == GAP && gap_end && !last) index <= index + TBL_AW'(1);
      if (state == DONE) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
      if (state == ERR) begin
        busy <= 1'b0;
        error <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// tb_i2c_cfg_sequencer: scoreboard bench with a ROM model, an I2C configure-block model and a table-walk reference.
module tb_i2c_cfg_sequencer;
  localparam int AW = 8;
  localparam int DEPTH = 256;
  localparam int GAP = 30;
  localparam int ACK = 200;
  localparam int DTO = 600;
  localparam logic [31:0] END_W = 32'hFFFF_FFFF;
  localparam int M_OK = 0, M_NODROP = 1, M_NORISE1 = 2;
  logic clk_24m = 1'b0, reset, start, busy, done, error, configure_en, configure_rdy;
  logic [AW-1:0] cur_index, tbl_addr;
  logic [31:0] tbl_data, configure_data;
  logic [31:0] rom [DEPTH];
  logic [31:0] exp_q [$];
  logic [31:0] rise_data, held;
  int n_chk = 0, n_pass = 0, cyc = 0, mode = M_OK, exp_idx = 0;
  int prev_rise = -1, last_rise = 0, last_fall = 0, last_delta = 0, err_cyc = 0, term = 0;
  logic en_q = 1'b0, err_q = 1'b0;

  i2c_cfg_sequencer #(.TBL_AW(AW), .GAP_CYCLES(GAP), .ACK_TIMEOUT(ACK), .DONE_TIMEOUT(DTO),
                      .END_WORD(END_W)) dut (
    .clk_24m(clk_24m), .reset(reset), .start(start), .busy(busy), .done(done), .error(error),
    .cur_index(cur_index), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .configure_en(configure_en), .configure_data(configure_data), .configure_rdy(configure_rdy));

  initial forever #5 clk_24m = ~clk_24m;
  always @(posedge clk_24m) cyc <= cyc + 1;
  always @(posedge clk_24m) tbl_data <= rom[tbl_addr];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
  endtask

  task automatic check_rng(input string nm, input int got, input int lo, input int hi);
    n_chk++;
    if (got >= lo && got <= hi) n_pass++;
    else $display("FAIL %s got=%0d want=[%0d,%0d]", nm, got, lo, hi);
  endtask

  // I2C configure block: accepts a word a few cycles after en, finishes some tens of cycles later
  initial begin
    configure_rdy = 1'b1;
    forever begin
      @(negedge clk_24m);
      if (configure_en && mode != M_NODROP) begin
        held = configure_data;
        repeat ($urandom_range(2, 10)) @(negedge clk_24m);
        configure_rdy = 1'b0;
        repeat ($urandom_range(10, 40)) @(negedge clk_24m);
        while (mode == M_NORISE1 && held == rom[1]) @(negedge clk_24m);
        configure_rdy = 1'b1;
      end
    end
  end

  always @(negedge clk_24m) begin
    if (configure_en && !en_q) begin
      if (exp_q.size() == 0) check("unexpected_issue", configure_data, 32'hDEAD_0000);
      else check("issue_data", configure_data, exp_q.pop_front());
      if (prev_rise >= 0) begin
        last_delta = cyc - prev_rise;
        check_rng("issue_spacing", last_delta, GAP, 1 << 30);
      end
      prev_rise = cyc;
      last_rise = cyc;
      rise_data = configure_data;
    end
    if (!configure_en && en_q) begin
      last_fall = cyc;
      if (!reset) check("data_stable", configure_data, rise_data);
    end
    if (error && !err_q) err_cyc = cyc;
    en_q = configure_en;
    err_q = error;
  end

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w[31:24] == 8'hFE || w == END_W) w[31] = 1'b0;
    return w;
  endfunction

  // Reference walk: words issued in order up to the terminator or table end, none past 'limit'
  function automatic void build_expect(input int limit);
    exp_q.delete();
    exp_idx = DEPTH - 1;
    for (int i = 0; i < DEPTH; i++) begin
      if (rom[i] == END_W) begin
        exp_idx = i;
        break;
      end
`ifdef I2C_SEQ_DELAY_CMD_EN
      if (rom[i][31:24] == 8'hFE) continue;
`endif
      if (i <= limit) exp_q.push_back(rom[i]);
    end
  endfunction

  task automatic load_basic();
    for (int i = 0; i < DEPTH; i++) rom[i] = rand_word();
    rom[0] = 32'h0010_2233;
    rom[1] = 32'h0011_4455;
    rom[2] = 32'h0012_6677;
    rom[3] = END_W;
  endtask

  task automatic run(input int mid);
    for (int k = 0; !configure_rdy && k < 2000; k++) @(negedge clk_24m);
    prev_rise = -1;
    start = 1'b1;
    @(negedge clk_24m);
    start = 1'b0;
    check("busy_on_start", 32'(busy), 1);
    check("done_cleared", 32'(done), 0);
    check("error_cleared", 32'(error), 0);
    for (int k = 0; busy && k < 40000; k++) begin
      @(negedge clk_24m);
      start = k == mid;
    end
    start = 1'b0;
    check("run_finished", 32'(busy), 0);
    @(negedge clk_24m);
  endtask

  task automatic check_end(input int d, input int e, input int idx);
    check("done", 32'(done), d);
    check("error", 32'(error), e);
    check("busy_end", 32'(busy), 0);
    check("en_end", 32'(configure_en), 0);
    check("cur_index", 32'(cur_index), idx);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    for (int i = 0; i < DEPTH; i++) rom[i] = 32'h0;
    repeat (3) @(negedge clk_24m);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_error", 32'(error), 0);
    check("rst_en", 32'(configure_en), 0);
    check("rst_data", configure_data, 0);
    check("rst_index", 32'(cur_index), 0);
    check("rst_addr", 32'(tbl_addr), 0);
    reset = 1'b0;
    @(negedge clk_24m);

    load_basic();
    build_expect(DEPTH);
    run(-1);
    check_end(1, 0, exp_idx);

    build_expect(DEPTH);
    run(150);
    check_end(1, 0, exp_idx);
    build_expect(DEPTH);
    run(-1);
    check_end(1, 0, exp_idx);

    mode = M_NODROP;
    build_expect(0);
    run(-1);
    mode = M_OK;
    check_end(0, 1, 0);
    check_rng("ack_timeout_lat", err_cyc - last_rise, ACK + 1, ACK + 3);

    mode = M_NORISE1;
    build_expect(1);
    run(-1);
    mode = M_OK;
    check_end(0, 1, 1);
    check_rng("done_timeout_lat", err_cyc - last_fall, DTO + 1, DTO + 3);

    for (int r = 0; r < 3; r++) begin
      term = $urandom_range(2, 8);
      for (int i = 0; i < DEPTH; i++) rom[i] = rand_word();
      rom[$urandom_range(0, term - 1)] = 32'hFE00_0002;
      rom[term] = END_W;
      build_expect(DEPTH);
      run(-1);
      check_end(1, 0, exp_idx);
    end

    for (int i = 0; i < DEPTH; i++) rom[i] = rand_word();
    build_expect(DEPTH);
    run(-1);
    check_end(1, 0, DEPTH - 1);

    load_basic();
    build_expect(DEPTH);
    for (int k = 0; !configure_rdy && k < 2000; k++) @(negedge clk_24m);
    prev_rise = -1;
    start = 1'b1;
    @(negedge clk_24m);
    start = 1'b0;
    for (int k = 0; !configure_en && k < 2000; k++) @(negedge clk_24m);
    check("en_before_reset", 32'(configure_en), 1);
    reset = 1'b1;
    @(negedge clk_24m);
    check("rst_mid_en", 32'(configure_en), 0);
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_done", 32'(done), 0);
    check("rst_mid_error", 32'(error), 0);
    @(negedge clk_24m);
    reset = 1'b0;
    exp_q.delete();

`ifdef I2C_SEQ_DELAY_CMD_EN
    load_basic();
    rom[1] = 32'hFE00_0005;
    build_expect(DEPTH);
    run(-1);
    check_end(1, 0, exp_idx);
    check_rng("delay_spacing", last_delta, 5 * GAP + GAP, 1 << 30);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/i2c_cfg_sequencer.md
Name: i2c_cfg_sequencer

Overview:
- Walks a table of 32-bit I2C configuration words at power-up or on request.
- Hands each word to the I2C configure block (configure_en / configure_data / configure_rdy) one at a time, waiting for each transaction to finish.
- Sits between the external synchronous config ROM and the I2C configure block.
- Reports busy, done, error and the current table index to software or the board-level controller.

Parameters:
- TBL_AW, 8, table address width; table depth = 2**TBL_AW.
- GAP_CYCLES, 24000, idle clk_24m cycles between successive words (1 ms).
- ACK_TIMEOUT, 240000, max cycles waiting for configure_rdy to fall after issue (10 ms).
- DONE_TIMEOUT, 2400000, max cycles waiting for configure_rdy to rise after acceptance (100 ms).
- END_WORD, 32'hFFFF_FFFF, table terminator value.

Ports:
- clk_24m  in  1  system clock, 24 MHz.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to run the table from index 0.
- busy  out  1  sequence in progress.
- done  out  1  last run completed without error; sticky until next start.
- error  out  1  last run aborted on timeout; sticky until next start.
- cur_index  out  TBL_AW  index of word being processed / index at abort.
- tbl_addr  out  TBL_AW  ROM address.
- tbl_data  in  32  ROM data, valid 1 cycle after tbl_addr changes.
- configure_en  out  1  request level to I2C configure block.
- configure_data  out  32  word to write; stable while configure_en=1.
- configure_rdy  in  1  1 = I2C configure block idle; slow-domain level.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0.
- configure_rdy passes through a 2-flop synchronizer (rdy_s); all decisions use rdy_s.
- IDLE:
  - start=1 → clear done/error, index=0, busy=1, go to FETCH.
  - start while busy=1 is ignored.
- FETCH: drive tbl_addr=index; stay 2 cycles; sample tbl_data on the 2nd cycle into configure_data.
- CHECK:
  - Sampled word == END_WORD → DONE.
  - Otherwise wait for rdy_s=1, then go to ISSUE. No timeout applies here.
- ISSUE:
  - configure_en=1, configure_data held.
  - Leave when rdy_s=0 (word accepted): configure_en=0 on the next cycle, go to WAIT_DONE.
  - Counter reaches ACK_TIMEOUT → ERR.
- WAIT_DONE:
  - configure_en=0.
  - rdy_s=1 → GAP.
  - Counter reaches DONE_TIMEOUT → ERR.
- GAP:
  - Count GAP_CYCLES.
  - If index == 2**TBL_AW-1 → DONE (table exhausted without terminator).
  - Else index+1 → FETCH.
- DONE: busy=0, done=1 → IDLE.
- ERR: busy=0, error=1, configure_en=0, cur_index frozen → IDLE.
- Timeout counters: 0 on state entry; compare with >=; widths sized to the largest parameter.
- cur_index tracks index; no wrap past the last entry.
- configure_en is never high outside ISSUE.
- reset mid-sequence: configure_en=0 on the next edge; the I2C transaction in flight completes externally and is not re-issued.

Optional Feature:
- Macro: I2C_SEQ_DELAY_CMD_EN.
- Defined:
  - A word with bits[31:24]=8'hFE is a delay command; it is not sent to I2C.
  - CHECK goes to a DELAY state that waits bits[15:0] × 24000 cycles (ms), then GAP.
  - configure_en stays 0 throughout.
- Undefined: 8'hFE words are sent as ordinary I2C words.

Test Plan:
- Table {32'h0010_2233, 32'h0011_4455, 32'h0012_6677, END_WORD} with a behavioural I2C configure model (rdy falls ~100 cycles after en, rises ~5000 cycles later) → exactly 3 configure_en pulses with the data in order, each ≥24000 cycles apart; done=1, error=0, busy=0; cur_index=3.
- Model never drops configure_rdy → error=1 exactly ACK_TIMEOUT(+sync) cycles after configure_en rises; configure_en=0; cur_index=0.
- Model drops rdy on word 1 but never raises it → error=1 after DONE_TIMEOUT; cur_index=1.
- start pulsed mid-run → ignored, run finishes normally; a second start after done → table replays from index 0 and done is cleared during the run.
- Table of 256 non-terminator words (TBL_AW=8) → 256 issues, done=1, cur_index=255, no address wrap.
- reset asserted while configure_en=1 → configure_en=0, busy=0, done=0, error=0 on the next edge.
- With I2C_SEQ_DELAY_CMD_EN, word 32'hFE00_0005 between two writes → no configure_en for ≥120000+24000 cycles between them.
